// File: rtl/red_pitaya_guitar_dac_out.sv
// Output conditioning ahead of the DAC: gain, click-free mute fade, saturation to 14 bits.
// Define RP_GUITAR_DAC_OFFSET_BIN_EN for an offset-binary DAC word (midscale reset value).
module red_pitaya_guitar_dac_out #(
    parameter int GAIN_FRAC = 8,
    parameter int ENV_W     = 10,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    input  logic [15:0] gain_i,
    input  logic        mute_i,
    output logic [13:0] dac_o,
    output logic        dac_valid_o,
    output logic        clip_o,
    output logic        muted_o
);

    localparam int P1_W = 33;
    localparam int G_W  = P1_W - GAIN_FRAC;
    localparam int P2_W = G_W + ENV_W + 2;
    localparam int E_W  = P2_W - ENV_W;

    localparam logic [ENV_W:0] ENV_MAX = {1'b1, {ENV_W{1'b0}}};
    localparam logic [ENV_W:0] STEP    = (ENV_W + 1)'(RAMP_STEP);

`ifdef RP_GUITAR_DAC_OFFSET_BIN_EN
    localparam logic [13:0] DAC_RST = 14'h2000;
`else
    localparam logic [13:0] DAC_RST = 14'h0000;
`endif

    typedef enum logic [1:0] {
        ST_MUTED,
        ST_FADE_IN,
        ST_ACTIVE,
        ST_FADE_OUT
    } state_t;

    state_t                 state_q;
    logic [ENV_W:0]         env_q;
    logic                   muted_q;

    logic [ENV_W+1:0]       env_sum;
    logic [ENV_W:0]         env_up;
    logic [ENV_W:0]         env_dn;
    logic                   go_up;
    logic                   go_dn;

    // Saturating envelope steps in both directions
    assign env_sum = {1'b0, env_q} + {1'b0, STEP};
    assign env_up  = (env_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : env_sum[ENV_W:0];
    assign env_dn  = (env_q > STEP) ? (env_q - STEP) : '0;

    always_comb begin
        go_up = 1'b0;
        go_dn = 1'b0;
        case (state_q)
            ST_MUTED: go_up = !mute_i;
            ST_FADE_IN, ST_FADE_OUT: begin
                go_up = !mute_i;
                go_dn = mute_i;
            end
            ST_ACTIVE: go_dn = mute_i;
            default: begin
                go_up = 1'b0;
                go_dn = 1'b0;
            end
        endcase
    end

    // A mute reversal on the boundary cycle redirects the ramp, so ACTIVE/MUTED
    // are only entered when the step was taken in their own direction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_MUTED;
            env_q   <= '0;
            muted_q <= 1'b1;
        end else if (go_up) begin
            if (sample_valid_i) begin
                env_q <= env_up;
            end
            if (sample_valid_i && (env_up == ENV_MAX)) begin
                state_q <= ST_ACTIVE;
            end else begin
                state_q <= ST_FADE_IN;
            end
            muted_q <= 1'b0;
        end else if (go_dn) begin
            if (sample_valid_i) begin
                env_q <= env_dn;
            end
            if (sample_valid_i && (env_dn == '0)) begin
                state_q <= ST_MUTED;
                muted_q <= 1'b1;
            end else begin
                state_q <= ST_FADE_OUT;
                muted_q <= 1'b0;
            end
        end
    end

    logic signed [P1_W-1:0] prod1;
    logic signed [G_W-1:0]  g_d;
    logic signed [G_W-1:0]  g1_q;
    logic [ENV_W:0]         env1_q;
    logic                   v1_q;

    assign prod1 = P1_W'($signed(sample_i)) * P1_W'($signed({1'b0, gain_i}));
    assign g_d   = prod1[P1_W-1:GAIN_FRAC];

    // S1 latches the envelope in force before this sample's own step
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g1_q   <= '0;
            env1_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            g1_q   <= g_d;
            env1_q <= env_q;
            v1_q   <= sample_valid_i;
        end
    end

    logic signed [P2_W-1:0] prod2;
    logic signed [E_W-1:0]  e_d;
    logic signed [E_W-1:0]  e2_q;
    logic                   v2_q;

    assign prod2 = P2_W'(g1_q) * P2_W'($signed({1'b0, env1_q}));
    assign e_d   = prod2[P2_W-1:ENV_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e2_q <= '0;
            v2_q <= 1'b0;
        end else begin
            e2_q <= e_d;
            v2_q <= v1_q;
        end
    end

    logic        pos_ovf;
    logic        neg_ovf;
    logic [15:0] s16;
    logic [13:0] dac_word;

    assign pos_ovf = !e2_q[E_W-1] && (|e2_q[E_W-2:15]);
    assign neg_ovf = e2_q[E_W-1] && !(&e2_q[E_W-2:15]);
    assign s16     = pos_ovf ? 16'h7FFF : (neg_ovf ? 16'h8000 : e2_q[15:0]);

`ifdef RP_GUITAR_DAC_OFFSET_BIN_EN
    assign dac_word = {~s16[15], s16[14:2]};
`else
    assign dac_word = s16[15:2];
`endif

    logic [13:0] dac_q;
    logic        clip_q;
    logic        vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dac_q  <= DAC_RST;
            clip_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= v2_q;
            if (v2_q) begin
                dac_q  <= dac_word;
                clip_q <= pos_ovf | neg_ovf;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{prod1[GAIN_FRAC-1:0], prod2[ENV_W-1:0], s16[1:0]};

    assign dac_o       = dac_q;
    assign dac_valid_o = vld_q;
    assign clip_o      = clip_q;
    assign muted_o     = muted_q;

endmodule

// File: tb/tb_red_pitaya_guitar_dac_out.sv
// Scoreboard bench for red_pitaya_guitar_dac_out: fade ramps, saturation, mute reversal,
// gapped valids and reset abort. Honours RP_GUITAR_DAC_OFFSET_BIN_EN when defined.
module tb_red_pitaya_guitar_dac_out;

    localparam int ENV_MAX = 1024;
    localparam int RAMP    = 1;
    localparam int M_MUTED = 0;
    localparam int M_IN    = 1;
    localparam int M_ACT   = 2;
    localparam int M_OUT   = 3;

`ifdef RP_GUITAR_DAC_OFFSET_BIN_EN
    localparam logic [13:0] RST_DAC = 14'h2000;
`else
    localparam logic [13:0] RST_DAC = 14'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic [15:0] gain_i = '0;
    logic        mute_i = 1'b1;
    logic [13:0] dac_o;
    logic        dac_valid_o;
    logic        clip_o;
    logic        muted_o;

    red_pitaya_guitar_dac_out dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .gain_i         (gain_i),
        .mute_i         (mute_i),
        .dac_o          (dac_o),
        .dac_valid_o    (dac_valid_o),
        .clip_o         (clip_o),
        .muted_o        (muted_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] dac;
        logic        clip;
        int          t;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_txn = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          env_m = 0;
    int          st_m = M_MUTED;
    logic [13:0] last_dac = RST_DAC;
    logic        last_clip = 1'b0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t expect_out(input logic [15:0] s, input logic [15:0] g, input int env);
        exp_t   r;
        longint p;
        longint e;
        longint sv;
        logic [13:0] d;
        p  = longint'($signed(s)) * longint'(g);
        e  = ((p >>> 8) * longint'(env)) >>> 10;
        r.clip = (e > 32767) || (e < -32768);
        sv = (e > 32767) ? 32767 : ((e < -32768) ? -32768 : e);
        d  = 14'(sv >>> 2);
`ifdef RP_GUITAR_DAC_OFFSET_BIN_EN
        d[13] = ~d[13];
`endif
        r.dac = d;
        r.t   = 0;
        return r;
    endfunction

    // Envelope reference: direction follows mute_i, the step only happens on valids
    task automatic model_step(input logic v, input logic m);
        bit up;
        bit dn;
        up = !m && (st_m != M_ACT);
        dn = m && (st_m != M_MUTED);
        if (up) begin
            if (v) env_m = (env_m + RAMP > ENV_MAX) ? ENV_MAX : env_m + RAMP;
            st_m = (v && env_m == ENV_MAX) ? M_ACT : M_IN;
        end else if (dn) begin
            if (v) env_m = (env_m - RAMP < 0) ? 0 : env_m - RAMP;
            st_m = (v && env_m == 0) ? M_MUTED : M_OUT;
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic [15:0] g,
                         input logic m, input logic r);
        exp_t x;
        @(negedge clk);
        rst_i          = r;
        sample_valid_i = v;
        sample_i       = s;
        gain_i         = g;
        mute_i         = m;
        if (r) begin
            sb_q.delete();
            env_m     = 0;
            st_m      = M_MUTED;
            last_dac  = RST_DAC;
            last_clip = 1'b0;
        end else begin
            if (v) begin
                x   = expect_out(s, g, env_m);
                x.t = cyc;
                sb_q.push_back(x);
            end
            model_step(v, m);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t x;
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            if (dac_valid_o) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_valid", 1, 0);
                end else begin
                    x = sb_q.pop_front();
                    n_txn++;
                    $display("txn %0d: dac=0x%04h clip=%0d (exp 0x%04h/%0d)",
                             n_txn, dac_o, clip_o, x.dac, x.clip);
                    check_eq("dac", dac_o, x.dac);
                    check_eq("clip", clip_o, x.clip);
                    check_eq("latency", cyc - x.t, 3);
                    last_dac  = x.dac;
                    last_clip = x.clip;
                end
            end else begin
                check_eq("hold_dac", dac_o, last_dac);
                check_eq("hold_clip", clip_o, last_clip);
            end
            check_eq("muted", muted_o, (st_m == M_MUTED));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        settle();
        check_eq("rst_dac", dac_o, RST_DAC);
        check_eq("rst_valid", dac_valid_o, 0);
        check_eq("rst_clip", clip_o, 0);
        check_eq("rst_muted", muted_o, 1);
        mon_en = 1'b1;

        // Fade in to ACTIVE at unity gain
        for (int i = 0; i < 1030; i++) drive(1'b1, 16'h4000, 16'd256, 1'b0, 1'b0);
        settle();
        check_eq("active_unmuted", muted_o, 0);

        // Saturation and small-signal in ACTIVE
        drive(1'b1, 16'h7000, 16'd512, 1'b0, 1'b0);
        drive(1'b1, 16'h8000, 16'd512, 1'b0, 1'b0);
        drive(1'b1, 16'h0100, 16'd256, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            drive(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 1023)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0, 16'd256, 1'b0, 1'b0);

        // Fade out fully, then reverse a partial fade-in after 300 valids
        for (int i = 0; i < 1026; i++) drive(1'b1, 16'h4000, 16'd256, 1'b1, 1'b0);
        settle();
        check_eq("muted_after_fadeout", muted_o, 1);
        for (int i = 0; i < 300; i++) drive(1'b1, 16'h4000, 16'd256, 1'b0, 1'b0);
        for (int i = 0; i < 299; i++) drive(1'b1, 16'h4000, 16'd256, 1'b1, 1'b0);
        settle();
        check_eq("not_muted_at_299", muted_o, 0);
        drive(1'b1, 16'h4000, 16'd256, 1'b1, 1'b0);
        settle();
        check_eq("muted_at_300", muted_o, 1);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h4000, 16'd256, 1'b1, 1'b0);

        // Gapped valids while fading out
        for (int i = 0; i < 200; i++) drive(1'b1, 16'h4000, 16'd256, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            drive((i % 4) == 0, 16'($urandom_range(0, 65535)), 16'($urandom_range(128, 767)), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h1234, 16'd256, 1'b1, 1'b0);

        // Reach ACTIVE, then reset with samples in flight
        for (int i = 0; i < 1100; i++) drive(1'b1, 16'h4000, 16'd256, 1'b0, 1'b0);
        settle();
        check_eq("active_before_rst", muted_o, 0);
        drive(1'b1, 16'h4000, 16'd256, 1'b0, 1'b1);
        settle();
        check_eq("midrst_dac", dac_o, RST_DAC);
        check_eq("midrst_valid", dac_valid_o, 0);
        check_eq("midrst_muted", muted_o, 1);
        check_eq("midrst_clip", clip_o, 0);
        for (int i = 0; i < 6; i++) drive(1'b0, 16'h4000, 16'd256, 1'b0, 1'b0);
        settle();
        check_eq("drained", sb_q.size(), 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/red_pitaya_guitar_dac_out.md
Name: red_pitaya_guitar_dac_out

Overview:
Output conditioning stage that sits directly downstream of the guitar effect and test-signal sources, such as the square generator, and directly upstream of the DAC pins. It takes a signed 16-bit sample and applies a programmable gain. It then applies a click-free mute/unmute fade envelope, saturates to the 14-bit DAC range and registers the DAC word. A fade state machine ramps the envelope, one step per valid sample.

Parameters:
GAIN_FRAC, 8, fractional bits of gain_i (unsigned Q8.8, 256 = unity)
ENV_W, 10, envelope fraction width; ENV_MAX = 2**ENV_W (1024 = unity)
RAMP_STEP, 1, envelope increment/decrement per valid sample (1..ENV_MAX)

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
sample_i  input  16  signed two's-complement input sample
sample_valid_i  input  1  sample_i is valid this cycle
gain_i  input  16  unsigned gain, Q8.8
mute_i  input  1  level: 1 = fade to silence, 0 = fade to full level
dac_o  output  14  DAC word; two's complement, or offset binary per the optional feature
dac_valid_o  output  1  dac_o updated this cycle
clip_o  output  1  saturation occurred on the sample presented with dac_valid_o
muted_o  output  1  state machine is in MUTED

Behaviour:
- Reset (rst_i=1 on a clock edge):
  - state=MUTED, env=0, pipeline valid bits=0.
  - dac_o=14'h0000 (14'h2000 with the optional feature); dac_valid_o=0, clip_o=0, muted_o=1.
  - Reset mid-fade or while ACTIVE aborts immediately; no ramp-down.
- Pipeline, 3 cycles, fully pipelined; one sample per cycle is accepted:
  - S1: g = (sample_i * {1'b0,gain_i}) >>> GAIN_FRAC, signed, at least 25 bits.
  - S2: e = (g * env) >>> ENV_W, with env unsigned ENV_W+1 bits.
  - S3: saturate e to [-32768, 32767], giving s16. dac_o = s16[15:2] (truncation). clip_o=1 if e was out of range.
- dac_valid_o is sample_valid_i delayed by 3 cycles. dac_o and clip_o hold their values between valids.
- The envelope value used for a sample is env before that sample's update.
- Fade FSM states: MUTED, FADE_IN, ACTIVE, FADE_OUT. env changes only on cycles with sample_valid_i=1.
  - MUTED (env=0): mute_i=0 -> FADE_IN.
  - FADE_IN: on each valid, env = min(env+RAMP_STEP, ENV_MAX). When the new env equals ENV_MAX -> ACTIVE. mute_i=1 -> FADE_OUT, starting from the current env with no jump.
  - ACTIVE (env=ENV_MAX): mute_i=1 -> FADE_OUT.
  - FADE_OUT: on each valid, env = max(env-RAMP_STEP, 0). When the new env equals 0 -> MUTED. mute_i=0 -> FADE_IN from the current env.
- Simultaneous events:
  - A mute_i change and a valid in the same cycle: the transition is taken and that valid's step applies in the new state's direction.
  - A boundary being reached and a mute_i reversal in the same cycle: mute_i wins. The FSM goes to FADE_IN or FADE_OUT, not ACTIVE or MUTED.
- No sample_valid_i: env freezes, and the state can still change on mute_i.
- gain_i is sampled in S1 each cycle; changes take effect on the next accepted sample. There is no gain smoothing.
- muted_o is registered, asserted iff state==MUTED.

Optional Feature:
- Macro: RP_GUITAR_DAC_OFFSET_BIN_EN.
- Defined: dac_o = {~s16[15], s16[14:2]}, i.e. offset binary, and the reset value of dac_o is 14'h2000 (midscale).
- Undefined: dac_o = s16[15:2] two's complement, and the reset value is 14'h0000.
- Pipeline latency and clip_o are identical in both builds.

Test Plan:
1. Reset: hold rst_i high for 3 cycles -> dac_o=0, dac_valid_o=0, clip_o=0, muted_o=1. With the macro, dac_o=0x2000.
2. Fade in: mute_i=0, gain_i=256, sample_i=0x4000, valid every cycle.
   - The first dac_o is 0.
   - dac_o rises monotonically and reaches 0x1000 after 1024 valids; the FSM enters ACTIVE and muted_o=0.
   - dac_valid_o trails sample_valid_i by exactly 3 cycles.
3. Saturation, ACTIVE:
   - gain_i=512, sample_i=0x7000 -> dac_o=0x1FFF, clip_o=1.
   - sample_i=0x8000 -> dac_o=0x2000, clip_o=1.
   - gain_i=256, sample_i=0x0100 -> dac_o=0x0040, clip_o=0.
4. Mute reversal: in FADE_IN, set mute_i=1 after 300 valids (env=300) -> env decreases by 1 per valid. MUTED and muted_o=1 after exactly 300 more valids, and dac_o returns to 0.
5. Gapped valids: in FADE_OUT, pulse sample_valid_i 1 cycle in 4 -> env changes only on valid cycles, and dac_o/clip_o hold between dac_valid_o pulses.
6. Reset mid-ACTIVE with sample_i=0x4000: assert rst_i for 1 cycle -> next cycle dac_o=0, dac_valid_o=0, muted_o=1. No pipelined samples emerge afterwards.
